// File: rtl/response_checker_pkg.sv
// Shared types and helpers for the response capture checker: FSM states,
// default geometry and the MISR next-state function.
package response_checker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int              DEF_N_IN  = 5;
   localparam int              DEF_SIG_W = 16;
   localparam logic [15:0]     DEF_POLY  = 16'h1021;

   // One MISR step: shift, fold the feedback polynomial when the MSB falls out,
   // then absorb the new (zero-extended) data word.
   function automatic logic [DEF_SIG_W-1:0] misr_next(
      input logic [DEF_SIG_W-1:0] sig,
      input logic [DEF_SIG_W-1:0] poly,
      input logic [DEF_SIG_W-1:0] data
   );
      return (sig << 1) ^ (sig[DEF_SIG_W-1] ? poly : '0) ^ data;
   endfunction

endpackage

// File: rtl/response_gold_mem.sv
// DEPTH x 1 golden response table: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded table survives a reset.
module response_gold_mem #(
   parameter int N_IN  = 5,
   parameter int DEPTH = 2**N_IN
) (
   input  logic            CK,
   input  logic            we,
   input  logic [N_IN-1:0] waddr,
   input  logic            wdata,
   input  logic [N_IN-1:0] raddr,
   output logic            rdata
);

   logic mem [DEPTH];

   always_ff @(posedge CK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/response_capture_checker.sv
// Consumes (vector, response) pairs of an exhaustive sweep, checks them against
// a golden table, counts mismatches, records the first failure and builds a MISR.
module response_capture_checker
   import response_checker_pkg::*;
#(
   parameter int                N_IN  = DEF_N_IN,
   parameter int                DEPTH = 2**N_IN,
   parameter int                SIG_W = DEF_SIG_W,
   parameter logic [SIG_W-1:0]  POLY  = DEF_POLY[SIG_W-1:0]
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             gold_we,
   input  logic [N_IN-1:0]  gold_addr,
   input  logic             gold_data,
   input  logic             start,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [N_IN-1:0]  vec_in,
   input  logic             resp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    mismatch_cnt,
   output logic             seq_err,
   output logic             first_fail_valid,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic [SIG_W-1:0] signature
);

   state_t          state_q, state_d;
   logic [N_IN-1:0] seq_cnt_q;
   logic            gold_rd;
   logic            hs, sweep_start, last_hs, miss;
   logic [N_IN:0]   mis_cnt_d;
   logic            seq_err_d;

   assign hs          = vec_valid && vec_ready;
   assign sweep_start = start && (state_q != RUN);
   assign last_hs     = hs && (seq_cnt_q == N_IN'(DEPTH - 1));
   assign miss        = (resp_in != gold_rd);

   // The table is frozen while a sweep is running.
   response_gold_mem #(
      .N_IN  (N_IN),
      .DEPTH (DEPTH)
   ) u_gold (
      .CK    (CK),
      .we    (gold_we && (state_q != RUN)),
      .waddr (gold_addr),
      .wdata (gold_data),
      .raddr (vec_in),
      .rdata (gold_rd)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)   state_d = RUN;
         RUN:     if (last_hs) state_d = DONE;
         DONE:    if (start)   state_d = RUN;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      mis_cnt_d = mismatch_cnt;
      if (miss && (mismatch_cnt != (N_IN+1)'(DEPTH))) mis_cnt_d = mismatch_cnt + (N_IN+1)'(1);
      seq_err_d = seq_err || (vec_in != seq_cnt_q);
   end

   assign vec_ready = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         seq_cnt_q        <= '0;
         mismatch_cnt     <= '0;
         seq_err          <= 1'b0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         signature        <= '0;
         pass             <= 1'b0;
      end else begin
         state_q <= state_d;
         if (sweep_start) begin
            seq_cnt_q        <= '0;
            mismatch_cnt     <= '0;
            seq_err          <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            signature        <= '0;
            pass             <= 1'b0;
         end else if (hs) begin
            mismatch_cnt <= mis_cnt_d;
            seq_err      <= seq_err_d;
            seq_cnt_q    <= seq_cnt_q + N_IN'(1);
            signature    <= misr_next(signature, POLY, SIG_W'({vec_in, resp_in}));
            if (miss && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_vec   <= vec_in;
            end
            // Verdict uses the values including this final pair.
            if (last_hs) pass <= (mis_cnt_d == '0) && !seq_err_d;
         end
      end
   end

endmodule

// File: tb/tb_response_capture_checker.sv
// Scoreboard bench for response_capture_checker: directed sweeps push expected
// results; a monitor pops and compares when done rises.
module tb_response_capture_checker;

   localparam int N_IN  = 5;
   localparam int DEPTH = 32;
   localparam int SIG_W = 16;

   logic             CK = 1'b0;
   logic             reset = 1'b0;
   logic             gold_we = 1'b0;
   logic [N_IN-1:0]  gold_addr = '0;
   logic             gold_data = 1'b0;
   logic             start = 1'b0;
   logic             vec_valid = 1'b0;
   logic             vec_ready;
   logic [N_IN-1:0]  vec_in = '0;
   logic             resp_in = 1'b0;
   logic             busy, done, pass, seq_err, first_fail_valid;
   logic [N_IN:0]    mismatch_cnt;
   logic [N_IN-1:0]  first_fail_vec;
   logic [SIG_W-1:0] signature;

   response_capture_checker dut (
      .CK               (CK),
      .reset            (reset),
      .gold_we          (gold_we),
      .gold_addr        (gold_addr),
      .gold_data        (gold_data),
      .start            (start),
      .vec_valid        (vec_valid),
      .vec_ready        (vec_ready),
      .vec_in           (vec_in),
      .resp_in          (resp_in),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .mismatch_cnt     (mismatch_cnt),
      .seq_err          (seq_err),
      .first_fail_valid (first_fail_valid),
      .first_fail_vec   (first_fail_vec),
      .signature        (signature)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic [5:0]  mcnt;
      logic        ffv;
      logic [4:0]  ffvec;
      logic        serr;
      logic        pass;
      logic [15:0] sig;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic gold_m [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [5:0] d);
      logic [15:0] r;
      r = {s[14:0], 1'b0};
      if (s[15]) r = r ^ 16'h1021;
      r = r ^ {10'd0, d};
      return r;
   endfunction

   // Monitor: counts handshakes and scores each sweep when done rises.
   int   cyc = 0;
   int   hs_cnt = 0;
   int   last_hs_cyc = -10;
   logic done_d = 1'b0;

   always @(negedge CK) begin
      exp_t e;
      cyc++;
      if (start && !busy) hs_cnt = 0;
      if (done && !done_d) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: done rose with no sweep outstanding");
         end else begin
            e = exp_q.pop_front();
            chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mcnt));
            chk("first_fail_valid", 32'(first_fail_valid), 32'(e.ffv));
            chk("first_fail_vec", 32'(first_fail_vec), 32'(e.ffvec));
            chk("seq_err", 32'(seq_err), 32'(e.serr));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("signature", 32'(signature), 32'(e.sig));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("vec_ready_at_done", 32'(vec_ready), 32'd0);
            chk("handshakes_at_done", 32'(hs_cnt), 32'(DEPTH));
            chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
         end
      end
      if (vec_valid && vec_ready) begin
         hs_cnt++;
         last_hs_cyc = cyc;
      end
      done_d = done;
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_vec_ready"}, 32'(vec_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
      chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
      chk({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
      chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'd0);
      chk({tag, "_signature"}, 32'(signature), 32'd0);
   endtask

   task automatic write_gold(input logic [4:0] a, input logic d);
      @(posedge CK);
      #1;
      gold_we = 1'b1; gold_addr = a; gold_data = d;
      gold_m[a] = d;
      @(posedge CK);
      #1;
      gold_we = 1'b0;
   endtask

   // flip: per-vector response inversion; abort_at: reset after that many handshakes (<0 = never)
   task automatic run_sweep(input logic [31:0] flip, input bit swap34, input bit bubbles,
                            input int abort_at, input bit we_in_run, input bit we_with_start);
      logic [4:0]  order [DEPTH];
      logic [4:0]  v;
      logic        r, vld, rdy;
      exp_t        e;
      int          guard;
      for (int i = 0; i < DEPTH; i++) order[i] = 5'(i);
      if (swap34) begin order[3] = 5'd4; order[4] = 5'd3; end
      if (we_with_start) gold_m[7] = ^5'd7;

      e.mcnt = '0; e.ffv = 1'b0; e.ffvec = '0; e.serr = 1'b0; e.sig = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v = order[i];
         r = (^v) ^ flip[v];
         if (r != gold_m[v]) begin
            e.mcnt++;
            if (!e.ffv) begin e.ffv = 1'b1; e.ffvec = v; end
         end
         if (v != 5'(i)) e.serr = 1'b1;
         e.sig = misr_ref(e.sig, {v, r});
      end
      e.pass = (e.mcnt == 0) && !e.serr;
      if (abort_at < 0) exp_q.push_back(e);

      @(posedge CK);
      #1;
      start = 1'b1;
      if (we_with_start) begin gold_we = 1'b1; gold_addr = 5'd7; gold_data = ^5'd7; end
      @(posedge CK);
      #1;
      start = 1'b0;
      gold_we = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         v = order[i];
         vec_in  = v;
         resp_in = (^v) ^ flip[v];
         guard = 0;
         do begin
            vld = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            vec_valid = vld;
            if (we_in_run && i == 10) begin
               gold_we = 1'b1; gold_addr = 5'd7; gold_data = ~(^5'd7);
            end
            rdy = vec_ready;
            @(posedge CK);
            #1;
            gold_we = 1'b0;
            guard++;
         end while (!(vld && rdy) && guard < 200);
         if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL handshake_timeout: vector %0d not accepted, vec_ready=%0b", i, vec_ready);
            vec_valid = 1'b0;
            return;
         end
         if (abort_at == i + 1) begin
            vec_valid = 1'b0;
            reset = 1'b0;
            #1;
            check_all_zero("abort");
            #2;
            reset = 1'b1;
            return;
         end
      end
      vec_valid = 1'b0;
      repeat (2) @(posedge CK);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      #12;
      check_all_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) write_gold(5'(i), ^(5'(i)));

      run_sweep(32'h0, 0, 0, -1, 0, 0);                          // clean back-to-back
      run_sweep((32'h1 << 13) | (32'h1 << 18), 0, 0, -1, 0, 0);  // two bad responses
      run_sweep(32'h0, 1, 0, -1, 0, 0);                          // vectors 3/4 swapped
      run_sweep(32'h0, 0, 1, -1, 0, 0);                          // bubbles
      run_sweep(32'h4, 0, 0, 10, 0, 0);                          // reset mid-sweep
      run_sweep(32'h0, 0, 0, -1, 0, 0);                          // fresh after reset
      run_sweep(32'h0, 0, 0, -1, 1, 0);                          // gold write during RUN ignored
      write_gold(5'd7, ~(^5'd7));                                // wrong entry after done
      run_sweep(32'h0, 0, 0, -1, 0, 0);
      run_sweep(32'h0, 0, 0, -1, 0, 1);                          // restore alongside start

      repeat (4) @(posedge CK);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
